// File: rtl/fifo_umbral_pkg.sv
// Shared defaults for the threshold FIFO and the control FSM that consumes
// its empty/error flags.
package fifo_umbral_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam logic [7:0] UMBRAL_RST = 8'h71;

  typedef struct packed {
    logic [3:0] high;
    logic [3:0] low;
  } umbral_t;
endpackage

// File: rtl/fifo_umbral_mem_fifo.sv
// Register-file storage for fifo_umbral: synchronous write, registered read port.
module mem_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read-before-write on a shared address: a full push+pop returns the old word.
  always_ff @(posedge clk or negedge reset)
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty/almost-full thresholds
// and a sticky overflow/underflow error flag.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [7:0]            umbral,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  fifo_error
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  umbral_t               thr;
  logic                  push_ok, pop_ok;

  assign pop_ok  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && ((count != DEPTH) || pop_ok);

  mem_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok && reset),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      fifo_error <= 1'b0;
      thr        <= umbral_t'(UMBRAL_RST);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      data_valid <= pop_ok;
      if ((push && !push_ok) || (pop && !pop_ok)) fifo_error <= 1'b1;
      if (init) thr <= umbral_t'(umbral);
    end
  end

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH);
  assign almost_empty = int'(count) <= int'(thr.low);
  assign almost_full  = int'(count) >= int'(thr.high);
endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: read data checked by a scoreboard monitor,
// occupancy and flags checked against hand-computed values.
module tb_fifo_umbral;
  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [7:0] umbral;
  logic [5:0] data_in, data_out;
  logic       data_valid;
  logic [3:0] count;
  logic       fifo_empty, fifo_full, almost_empty, almost_full, fifo_error;

  int vectors = 0;
  int miscompares = 0;
  logic [5:0] mq[$];     // words the model believes are stored
  logic [5:0] exp_q[$];  // expected read data, in order

  fifo_umbral dut (
    .clk(clk), .reset(reset), .init(init), .umbral(umbral),
    .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every data_valid must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && data_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: got data_out=%0h with nothing outstanding", data_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          miscompares++;
          $display("FAIL read_data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic cyc(input bit ps, input bit pp, input logic [5:0] d,
                     input bit in = 1'b0, input logic [7:0] u = 8'h00);
    bit pop_acc, push_acc;
    push = ps; pop = pp; data_in = d; init = in; umbral = u;
    pop_acc  = pp && (mq.size() > 0);
    push_acc = ps && ((mq.size() < 8) || pop_acc);
    if (pop_acc)  exp_q.push_back(mq.pop_front());
    if (push_acc) mq.push_back(d);
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; init = 1'b0;
  endtask

  task automatic do_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("outstanding_reads", exp_q.size(), 0);
    reset = 1'b0;
    #3;
    mq.delete(); exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0; umbral = 8'h00; data_in = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_error", fifo_error, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_dout", data_out, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Thresholds low=2, high=5
    cyc(0, 0, 0, 1, 8'h52);
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 6'(k));
      chk("fill_count", count, k);
      chk("fill_afull", almost_full, (k >= 5));
      chk("fill_aempty", almost_empty, (k <= 2));
    end
    for (int k = 0; k < 6; k++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_error", fifo_error, 0);

    // Overflow: 0x3F dropped, sticky error survives init
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 6'(8'h20 + i));
      if (i == 6) begin
        chk("seven_afull", almost_full, 1);
        chk("seven_full", fifo_full, 0);
      end
    end
    cyc(1, 0, 6'h3F);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_error", fifo_error, 1);
    chk("ovf_count", count, 8);
    cyc(0, 0, 0, 1, 8'h00);
    chk("init_keeps_error", fifo_error, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("ovf_drained", count, 0);
    chk("thr0_afull", almost_full, 1);
    chk("thr0_aempty", almost_empty, 1);

    // Underflow with simultaneous push
    do_reset();
    cyc(1, 1, 6'h15);
    chk("unf_error", fifo_error, 1);
    chk("unf_count", count, 1);
    chk("unf_valid", data_valid, 0);
    cyc(0, 1, 0);
    chk("unf_rd_valid", data_valid, 1);
    chk("unf_rd_data", data_out, 6'h15);

    // Full push+pop across pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 6'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 6'(8'h10 + i));
      chk("pp_count", count, 8);
    end
    chk("pp_error", fifo_error, 0);
    chk("pp_full", fifo_full, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("pp_empty", fifo_empty, 1);

    // Asynchronous reset between edges with count=5 and error set
    do_reset();
    cyc(1, 1, 6'h2A);
    for (int i = 0; i < 4; i++) cyc(1, 0, 6'(i));
    chk("pre_async_count", count, 5);
    chk("pre_async_error", fifo_error, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_empty", fifo_empty, 1);
    chk("async_error", fifo_error, 0);
    mq.delete();
    chk("async_outstanding", exp_q.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
